button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
// - Conditions raw pushbutton/switch inputs before they reach the up-counter En/Rst controls.
// - Per channel it provides:
//   - 2-flop synchronizer into Clk.
//   - Debounce FSM.
//   - Registered one-cycle Rise/Fall pulses and a press-toggled level.
// - Sits between the board BTNs pins and the counter top level, on the fast clock domain.
// PARAMETERS
// - WIDTH      2       number of independent button channels
// - DB_CYCLES  500000  consecutive stable Clk cycles required to accept a new level (min 2)
// - CNT_W      20      debounce counter width; must satisfy 2**CNT_W > DB_CYCLES
// PORTS
// - Clk     in   1      fast system clock; all state on rising edge
// - Rst     in   1      asynchronous, active-high reset
// - BtnIn   in   WIDTH  raw, asynchronous, bouncing button inputs
// - Level   out  WIDTH  debounced level per channel
// - Rise    out  WIDTH  1-cycle pulse on accepted 0->1 of Level
// - Fall    out  WIDTH  1-cycle pulse on accepted 1->0 of Level
// - Toggle  out  WIDTH  flips on every Rise of that channel
// BEHAVIOUR
// - Clocking and reset:
//   - Single clock domain; reset is asynchronous and active-high.
//   - Rst=1 forces immediately: sync flops=0, FSM=IDLE_LO, counter=0, Level=0, Rise=0, Fall=0, Toggle=0.
//   - Reset deassertion is sampled synchronously on the next Clk edge.
// - Synchronizer: s1<=BtnIn[i]; s2<=s1. The FSM only ever reads s2.
// - FSM per channel, independent, one shared design replicated with generate. States:
//   - IDLE_LO (Level=0):
//     - s2=1 -> WAIT_HI, cnt<=0.
//   - WAIT_HI (Level=0):
//     - s2=0 -> IDLE_LO, cnt<=0 (bounce rejected, no pulse).
//     - s2=1 and cnt==DB_CYCLES-1 -> IDLE_HI, Level<=1, Rise<=1, Toggle<=~Toggle.
//     - s2=1 otherwise -> cnt<=cnt+1.
//   - IDLE_HI (Level=1):
//     - s2=0 -> WAIT_LO, cnt<=0.
//   - WAIT_LO (Level=1):
//     - s2=1 -> IDLE_HI, cnt<=0 (bounce rejected).
//     - s2=0 and cnt==DB_CYCLES-1 -> IDLE_LO, Level<=0, Fall<=1.
//     - s2=0 otherwise -> cnt<=cnt+1.
// - Latency:
//   - BtnIn stable from before edge k: Level and Rise/Fall update after edge k+DB_CYCLES+2.
//     That is 2 sync edges, 1 entry edge, then DB_CYCLES counting edges.
// - Rise/Fall:
//   - Registered; high for exactly one Clk cycle per accepted transition.
//   - Cleared on every edge where no transition is accepted.
//   - Rise and Fall are never high together on one channel.
// - Glitch rejection:
//   - Any opposite s2 sample inside WAIT_* restarts the full DB_CYCLES window from IDLE_*.
//   - A glitch narrower than one Clk period may be missed entirely; this is acceptable.
// - Counter:
//   - cnt never exceeds DB_CYCLES-1; no wrap.
//   - Held only in WAIT_*; 0 in IDLE_*.
// - Channels are fully independent: simultaneous events on different channels each produce their own pulses in the same cycle.
// - Button held through reset release:
//   - Treated as a fresh press.
//   - Rise fires after the full latency measured from the first edge with Rst=0.
// - Reset mid-WAIT_*: counter discarded, no pulse emitted; Level stays at its reset value of 0.
// - Outputs are purely registered (no combinational path BtnIn->outputs).
// TESTING (bench uses WIDTH=2, DB_CYCLES=4, CNT_W=3)
// - Reset:
//   - Stimulus: Rst=1 for 3 cycles with BtnIn=2'b11.
//   - Expect: all outputs 0 throughout.
//   - Stimulus: release Rst at edge 0.
//   - Expect: Level[1:0]=11 and Rise=11 for exactly one cycle after edge 6; Toggle=11.
// - Clean press:
//   - Stimulus: BtnIn[0] 0->1 before edge k, held.
//   - Expect: Level[0]=1 and Rise[0]=1 after edge k+6; Rise[0]=0 after edge k+7; Fall[0]=0 throughout.
// - Bounce:
//   - Stimulus: BtnIn[0] pattern 1,1,0,1,1,0,1 (one cycle each), then held 1.
//   - Expect: no Rise until 6 edges after the final 0->1 sample; exactly one Rise[0].
// - Release and toggle:
//   - Stimulus: from Level[0]=1, drop BtnIn[0] before edge k.
//   - Expect: Fall[0] one cycle after edge k+6, Level[0]=0.
//   - Stimulus: a second press.
//   - Expect: Toggle[0] returns to 0.
// - Mid-operation reset:
//   - Stimulus: assert Rst asynchronously 2 cycles into WAIT_HI.
//   - Expect: outputs 0 immediately; no pulse after release unless a full 6-edge window follows.
// - Independence:
//   - Stimulus: press ch0 and release ch1 on the same edge.
//   - Expect: Rise[0] and Fall[1] in the same cycle, each one cycle wide.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw button inputs towards the
// conditioner and the conditioned level/pulse/toggle outputs back out.
interface button_conditioner_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] BtnIn;
    logic [WIDTH-1:0] Level;
    logic [WIDTH-1:0] Rise;
    logic [WIDTH-1:0] Fall;
    logic [WIDTH-1:0] Toggle;

    // Board/producer side: drives the raw buttons, observes the results
    modport master (
        output BtnIn,
        input  Level,
        input  Rise,
        input  Fall,
        input  Toggle
    );

    // Conditioner side
    modport slave (
        input  BtnIn,
        output Level,
        output Rise,
        output Fall,
        output Toggle
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel button conditioner: 2-flop synchronizer, debounce FSM,
// registered one-cycle Rise/Fall pulses and a press-toggled level.
module button_conditioner #(
    parameter int WIDTH     = 2,
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 20
) (
    input  logic                 Clk,
    input  logic                 Rst,
    button_conditioner_if.slave  bus
);

    localparam logic [1:0] IDLE_LO = 2'd0;
    localparam logic [1:0] WAIT_HI = 2'd1;
    localparam logic [1:0] IDLE_HI = 2'd2;
    localparam logic [1:0] WAIT_LO = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] level_vec;
    logic [WIDTH-1:0] rise_vec;
    logic [WIDTH-1:0] fall_vec;
    logic [WIDTH-1:0] toggle_vec;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        logic             s1_q, s2_q;
        logic [1:0]       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;
        logic             toggle_q, toggle_d;

        // Bring the asynchronous button into the Clk domain
        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= bus.BtnIn[g];
                s2_q <= s1_q;
            end
        end

        // Debounce decision: a level is accepted only after DB_CYCLES stable samples
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            level_d  = level_q;
            rise_d   = 1'b0;
            fall_d   = 1'b0;
            toggle_d = toggle_q;
            case (state_q)
                IDLE_LO: begin
                    if (s2_q) begin
                        state_d = WAIT_HI;
                        cnt_d   = '0;
                    end
                end
                WAIT_HI: begin
                    if (!s2_q) begin
                        state_d = IDLE_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d  = IDLE_HI;
                        cnt_d    = '0;
                        level_d  = 1'b1;
                        rise_d   = 1'b1;
                        toggle_d = ~toggle_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                IDLE_HI: begin
                    if (!s2_q) begin
                        state_d = WAIT_LO;
                        cnt_d   = '0;
                    end
                end
                WAIT_LO: begin
                    if (s2_q) begin
                        state_d = IDLE_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = IDLE_LO;
                        cnt_d   = '0;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end
            endcase
        end

        // FSM, counter and registered outputs
        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
                state_q  <= IDLE_LO;
                cnt_q    <= '0;
                level_q  <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                toggle_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                level_q  <= level_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
                toggle_q <= toggle_d;
            end
        end

        assign level_vec[g]  = level_q;
        assign rise_vec[g]   = rise_q;
        assign fall_vec[g]   = fall_q;
        assign toggle_vec[g] = toggle_q;
    end

    assign bus.Level  = level_vec;
    assign bus.Rise   = rise_vec;
    assign bus.Fall   = fall_vec;
    assign bus.Toggle = toggle_vec;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (WIDTH=2, DB_CYCLES=4, CNT_W=3).
// Reference model: two-stage sample delay plus a run-length rule -- a new
// level is accepted once DB_CYCLES+1 consecutive delayed samples differ
// from the current level.
module tb_button_conditioner;

    localparam int W  = 2;
    localparam int DB = 4;

    logic Clk;
    logic Rst;
    int   checks   = 0;
    int   failures = 0;

    button_conditioner_if #(.WIDTH(W)) bus_if ();

    button_conditioner #(
        .WIDTH(W),
        .DB_CYCLES(DB),
        .CNT_W(3)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus_if)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model state
    logic [W-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall, m_tog;
    int           m_run [W];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0;
        m_rise = '0; m_fall = '0; m_tog = '0;
        for (int c = 0; c < W; c++) m_run[c] = 0;
    endtask

    task automatic model_step();
        if (Rst) begin
            model_reset();
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < W; c++) begin
                if (m_s2[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB + 1) begin
                        m_run[c] = 0;
                        m_lvl[c] = ~m_lvl[c];
                        if (m_lvl[c]) begin
                            m_rise[c] = 1'b1;
                            m_tog[c]  = ~m_tog[c];
                        end else begin
                            m_fall[c] = 1'b1;
                        end
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = bus_if.BtnIn;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".Level"},  32'(bus_if.Level),  32'(m_lvl));
        check({tag, ".Rise"},   32'(bus_if.Rise),   32'(m_rise));
        check({tag, ".Fall"},   32'(bus_if.Fall),   32'(m_fall));
        check({tag, ".Toggle"}, 32'(bus_if.Toggle), 32'(m_tog));
    endtask

    task automatic tick(input string tag);
        @(posedge Clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    // Assert reset between edges and confirm outputs clear without a clock
    task automatic async_rst();
        #2;
        Rst = 1'b1;
        model_reset();
        #1;
        check("arst.Level",  32'(bus_if.Level),  32'd0);
        check("arst.Rise",   32'(bus_if.Rise),   32'd0);
        check("arst.Fall",   32'(bus_if.Fall),   32'd0);
        check("arst.Toggle", 32'(bus_if.Toggle), 32'd0);
    endtask

    initial begin
        int first_rise;
        int n_rise;
        logic [6:0] bounce;

        Rst = 1'b1;
        bus_if.BtnIn = 2'b11;
        model_reset();

        // Reset held with buttons pressed: everything stays 0
        for (int i = 0; i < 3; i++) begin
            tick("rst");
            check("rst.zero", 32'({bus_if.Level, bus_if.Rise, bus_if.Fall, bus_if.Toggle}), 32'd0);
        end

        // Button held through reset release is a fresh press
        Rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick("rel");
            check("rel.rise", 32'(bus_if.Rise), (i == 6) ? 32'd3 : 32'd0);
        end
        check("rel.toggle", 32'(bus_if.Toggle), 32'd3);
        check("rel.level",  32'(bus_if.Level),  32'd3);

        // Release ch0
        bus_if.BtnIn = 2'b10;
        for (int i = 0; i < 10; i++) begin
            tick("fall0");
            check("fall0.fall", 32'(bus_if.Fall[0]), (i == 6) ? 32'd1 : 32'd0);
        end
        check("fall0.level", 32'(bus_if.Level[0]), 32'd0);

        // Clean second press on ch0: Toggle returns to 0
        bus_if.BtnIn = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick("press0");
            check("press0.rise", 32'(bus_if.Rise[0]), (i == 6) ? 32'd1 : 32'd0);
            check("press0.nofall", 32'(bus_if.Fall[0]), 32'd0);
        end
        check("press0.toggle", 32'(bus_if.Toggle[0]), 32'd0);

        // Release again before the bounce test
        bus_if.BtnIn = 2'b10;
        for (int i = 0; i < 10; i++) tick("rel0");

        // Bounce 1,1,0,1,1,0,1 then held: one Rise, 6 edges after the last 0->1
        bounce     = 7'b1011011;
        first_rise = -1;
        n_rise     = 0;
        for (int i = 0; i < 16; i++) begin
            bus_if.BtnIn[0] = (i < 7) ? bounce[i] : 1'b1;
            tick("bounce");
            if (bus_if.Rise[0]) begin
                n_rise++;
                if (first_rise < 0) first_rise = i;
            end
        end
        check("bounce.count", 32'(n_rise), 32'd1);
        check("bounce.when",  32'(first_rise), 32'd12);

        // Independence: ch0 low, ch1 high, then swap on the same edge
        bus_if.BtnIn = 2'b10;
        for (int i = 0; i < 10; i++) tick("indep_pre");
        bus_if.BtnIn = 2'b01;
        for (int i = 0; i < 10; i++) begin
            tick("indep");
            check("indep.rise0", 32'(bus_if.Rise[0]), (i == 6) ? 32'd1 : 32'd0);
            check("indep.fall1", 32'(bus_if.Fall[1]), (i == 6) ? 32'd1 : 32'd0);
        end

        // Reset two cycles into WAIT_HI, then a full window after release
        bus_if.BtnIn = 2'b00;
        for (int i = 0; i < 10; i++) tick("mid_pre");
        bus_if.BtnIn = 2'b01;
        for (int i = 0; i < 5; i++) tick("mid_wait");
        async_rst();
        for (int i = 0; i < 2; i++) tick("mid_hold");
        Rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick("mid_after");
            check("mid.rise0", 32'(bus_if.Rise[0]), (i == 6) ? 32'd1 : 32'd0);
        end

        // Randomised bouncing with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            if (Rst) Rst = 1'b0;
            if ($urandom_range(5) == 0) bus_if.BtnIn[0] = ~bus_if.BtnIn[0];
            if ($urandom_range(5) == 0) bus_if.BtnIn[1] = ~bus_if.BtnIn[1];
            tick("rand");
            check("rand.excl", 32'(bus_if.Rise & bus_if.Fall), 32'd0);
            if ($urandom_range(149) == 0) async_rst();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
